// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i, wrapping.
module fifo_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int unsigned cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_o && req_i[IDX_W'(cand)]) begin
                any_o                  = 1'b1;
                idx_o                  = IDX_W'(cand);
                onehot_o[IDX_W'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of one async-FIFO write port among NUM_REQ producers.
// Optional per-requester word counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                          wr_clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_wr_error_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          burst_trunc_o,
    output logic                          err_o,
    output logic [NUM_REQ*STAT_W-1:0]     stat_cnt_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [BEAT_W-1:0]      beat_q, beat_d, beat_inc;
    logic                   trunc_q, trunc_d;
    logic                   err_q;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   owner_valid, owner_last;
    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : gen_unpack
        assign data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (req_valid_i),
        .rr_ptr_i (rr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign owner_valid = req_valid_i[owner_q];
    assign owner_last  = req_last_i[owner_q];
    assign beat_inc    = beat_q + BEAT_W'(1);

    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the combinational write-port path; ready never rises while full.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        beat_d       = beat_q;
        trunc_d      = 1'b0;
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        fifo_wdata_o = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_LOCK;
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    beat_d  = '0;
                end
            end
            ARB_LOCK: begin
                req_ready_o[owner_q] = !fifo_full_i;
                if (owner_valid && !fifo_full_i) begin
                    fifo_wr_en_o = 1'b1;
                    fifo_wdata_o = data_arr[owner_q];
                    beat_d       = beat_inc;
                    if (owner_last || (beat_inc == BEAT_W'(MAX_BURST))) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                        trunc_d = !owner_last;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            beat_q  <= '0;
            trunc_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            trunc_q <= trunc_d;
        end
    end

    // Sticky FIFO write-error flag.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (fifo_wr_error_i) begin
            err_q <= 1'b1;
        end
    end

    assign grant_o       = grant_q;
    assign burst_trunc_o = trunc_q;
    assign err_o         = err_q;

`ifdef FIFO_WR_ARB_STATS_EN
    // Saturating accepted-word counters, one per requester.
    for (genvar k = 0; k < NUM_REQ; k++) begin : gen_stat
        logic [STAT_W-1:0] cnt_q;

        always_ff @(posedge wr_clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (fifo_wr_en_o && (owner_q == IDX_W'(k)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + STAT_W'(1);
            end
        end

        assign stat_cnt_o[k*STAT_W +: STAT_W] = cnt_q;
    end
`else
    assign stat_cnt_o = '0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller that lets NUM_REQ independent producers share the single write port of an asynchronous FIFO. All logic runs in the FIFO write clock domain. Producers present bursts over a valid/ready handshake, and a round-robin arbiter locks one producer onto the port until its burst ends. The block sits directly in front of the FIFO write port and reacts to the FIFO's full and write-error flags.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: word width; matches the FIFO.
- MAX_BURST, 16: maximum words per grant, ≥1.

Ports:
- wr_clk_i  in  1  write-domain clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester word valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  flattened words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  marks the final word of a burst.
- req_ready_o  out  NUM_REQ  per-requester ready.
- fifo_wr_en_o  out  1  to the FIFO write enable.
- fifo_wdata_o  out  DATA_WIDTH  to the FIFO write data.
- fifo_full_i  in  1  FIFO full flag.
- fifo_wr_error_i  in  1  FIFO illegal-write pulse.
- grant_o  out  NUM_REQ  one-hot current owner; all zero when idle.
- burst_trunc_o  out  1  one-cycle pulse when a burst is cut at MAX_BURST.
- err_o  out  1  sticky; sets on any fifo_wr_error_i.
- stat_cnt_o  out  NUM_REQ*16  per-requester word counters (see Configuration).

## Operation
- State machine has two states, ARB_IDLE and ARB_LOCK.
- **ARB_IDLE**
  - If any req_valid_i is set, pick the first valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  - Register the winner as owner and go to ARB_LOCK.
  - grant_o is zero and req_ready_o is all zero in this state.
- **ARB_LOCK**
  - grant_o is one-hot on the owner.
  - req_ready_o[owner] = !fifo_full_i, combinational. All other ready bits are 0.
  - A transfer occurs when req_valid_i[owner] && req_ready_o[owner].
  - On a transfer: fifo_wr_en_o = 1 and fifo_wdata_o = req_data_i[owner], both combinational.
  - fifo_wr_en_o is never asserted while fifo_full_i is high.
- **Beat counter**
  - Width is $clog2(MAX_BURST+1).
  - Cleared on entry to ARB_LOCK; increments on each transfer.
- **Leaving ARB_LOCK** (back to ARB_IDLE):
  - On a transfer with req_last_i[owner] set.
  - On the transfer that brings the beat count to MAX_BURST without last; this also pulses burst_trunc_o the next cycle.
  - In both cases rr_ptr ← (owner+1) mod NUM_REQ.
- **Owner stalls** (req_valid_i low) keep the lock indefinitely; there is no timeout.
- fifo_wdata_o is 0 whenever fifo_wr_en_o is 0.
- err_o sets on any fifo_wr_error_i and clears only on reset.
- **Reset values:** state ARB_IDLE, rr_ptr 0, owner 0, grant_o 0, req_ready_o 0, fifo_wr_en_o 0, fifo_wdata_o 0, burst_trunc_o 0, err_o 0, stat_cnt_o 0.
- **Reset mid-burst:** the lock is dropped immediately. Words already written stay in the FIFO; the producer must restart its burst.

## Timing
- Arbitration costs one bubble cycle: a request seen in ARB_IDLE at edge n gives ready at the earliest in cycle n+1.
- Back-to-back bursts: last transfer at edge n, ARB_IDLE in cycle n+1, next owner locked in cycle n+2.
- Steady state inside a burst: one word per cycle while the FIFO is not full.
- Full handling:
  - fifo_full_i rising drops ready in the same cycle (combinational).
  - Transfers resume the cycle after full falls.
- Simultaneous events:
  - A new request arriving while another requester is locked waits; it is not preempted.
  - last coinciding with reaching MAX_BURST counts as a normal end; burst_trunc_o does not pulse.

## Configuration
- Macro: FIFO_WR_ARB_STATS_EN.
- **Defined:**
  - Each requester gets a 16-bit saturating counter of accepted words.
  - Counter k drives stat_cnt_o[k*16 +: 16].
  - Counters hold at 16'hFFFF once saturated.
  - Counters reset to 0.
- **Undefined:**
  - No counter logic is built.
  - stat_cnt_o is tied to 0; the port list is unchanged so instantiations stay identical.

## Structure
- Package fifo_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;
  - localparam STAT_W = 16.
- Sub-module fifo_rr_pick holds the combinational round-robin picker:
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner, winner index, any-valid.
- fifo_wr_arbiter holds the FSM, owner/rr_ptr registers, beat counter, data mux and statistics.

## Test plan
NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4 unless stated.
- **Single burst:** after reset, req 2 sends 0xA0..0xA2 with last on 0xA2 → grant_o=4'b0100 from cycle 1; three consecutive fifo_wr_en_o with those words; grant_o=0 afterwards.
- **Round-robin:** all four requesters continuously valid with 1-word bursts → grant order 0,1,2,3,0; one idle cycle between grants.
- **Full stall:** fifo_full_i forced high mid-burst for 5 cycles → req_ready_o and fifo_wr_en_o are 0 for exactly those cycles; no word is lost or duplicated.
- **Truncation:** req 1 sends 6 words with no last → after the 4th word burst_trunc_o pulses once and grant moves to req 2 if it is valid.
- **Error and reset:** inject a fifo_wr_error_i pulse → err_o=1 and stays set. Then assert rst_i mid-burst → all outputs return to their reset values asynchronously.
- **Statistics (FIFO_WR_ARB_STATS_EN defined):** 70000 words from req 0 → stat_cnt_o[15:0]=16'hFFFF. Without the macro → stat_cnt_o=0.
